lsu_mem_stage: RTL

- Load/store unit directly upstream of the data memory; converts execute-stage memory requests into word-level accesses on the DM port.
- Supports byte, halfword and word loads and stores; sign/zero-extends loads; detects misaligned accesses.
- Sub-word stores use read-modify-write, because DM only writes whole words.
- Drives the DM write strobe as a clean registered pulse, because DM captures writes on the rising edge of its write strobe and reads combinationally.

---
 rtl/lsu_pkg.sv | 61 ++++++
 rtl/lsu_if.sv | 32 +++
 rtl/lsu_align.sv | 44 ++++
 rtl/lsu_mem_stage.sv | 119 +++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit memory stage.
//   lsu_op_t    : request opcode encoding
//   lsu_state_t : FSM states of lsu_mem_stage
//   lsu_size_t  : access size class
//   is_load / is_store / op_size / is_misaligned : opcode helpers
package lsu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    OP_LW  = 3'b000,
    OP_LB  = 3'b001,
    OP_LBU = 3'b010,
    OP_LH  = 3'b011,
    OP_LHU = 3'b100,
    OP_SW  = 3'b101,
    OP_SB  = 3'b110,
    OP_SH  = 3'b111
  } lsu_op_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RMW_RD  = 3'd2,
    WSETUP  = 3'd3,
    WSTROBE = 3'd4,
    RESP    = 3'd5
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_t;

  function automatic logic is_load(lsu_op_t op);
    return op inside {OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU};
  endfunction

  function automatic logic is_store(lsu_op_t op);
    return op inside {OP_SW, OP_SB, OP_SH};
  endfunction

  function automatic lsu_size_t op_size(lsu_op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      default:              return SZ_WORD;
    endcase
  endfunction

  // Halfwords need an even address, words need a multiple of four.
  function automatic logic is_misaligned(lsu_op_t op, logic [1:0] addr_lo);
    case (op_size(op))
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response bus between the execute stage and the LSU.
//   master : execute side (drives requests, accepts responses)
//   slave  : LSU side
// Handshake: a transfer happens on a rising clock edge where valid and
// ready are both high. A source holds valid (and its payload) stable until
// the transfer; ready may depend on state but never on the payload.
interface lsu_if #(
  parameter int ADDR_W = 12
);
  import lsu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  lsu_op_t           req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane handling for the LSU.
//   word       : DM word read for this access
//   lane       : byte address bits [1:0]
//   op         : request opcode
//   wdata      : store data (sub-word data in the low bits)
//   load_data  : selected lane, sign/zero extended (LW passes word through)
//   store_word : word with the store byte/half merged in (SW: wdata)
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  lsu_op_t     op,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = word[{lane, 3'b000} +: 8];
    half_sel   = word[{lane[1], 4'b0000} +: 16];

    load_data  = word;
    case (op)
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'h000000, byte_sel};
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'h0000, half_sel};
      default: load_data = word;
    endcase

    store_word = word;
    case (op)
      OP_SB:   store_word[{lane, 3'b000} +: 8]      = wdata[7:0];
      OP_SH:   store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      OP_SW:   store_word                           = wdata;
      default: store_word                           = word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store unit in front of a word-wide data memory (DM).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/response interface (slave side)
//   dm_addr    : registered DM word address
//   dm_wr      : registered DM write strobe; DM writes on its rising edge
//   dm_din     : registered DM write word
//   dm_dout    : DM read data, combinational from dm_addr
//   busy       : high whenever the FSM is not IDLE
//   state_dbg  : current FSM state
// Sub-word stores read the old word, merge, then write the whole word.
// Writes go WSETUP (address/data settled, strobe low) then WSTROBE (strobe
// high one cycle) so DM sees a clean rising edge on stable inputs.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DM_AW  = ADDR_W - 2
) (
  input  logic             clk,
  input  logic             rst_n,
  lsu_if.slave             bus,
  output logic [DM_AW-1:0] dm_addr,
  output logic             dm_wr,
  output logic [31:0]      dm_din,
  input  logic [31:0]      dm_dout,
  output logic             busy,
  output lsu_state_t       state_dbg
);

  lsu_state_t  state, state_nxt;
  lsu_op_t     op_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  logic        accept;
  logic        req_misaligned;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign accept         = bus.req_valid && (state == IDLE);
  assign req_misaligned = is_misaligned(bus.req_op, bus.req_addr[1:0]);

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign busy           = (state != IDLE);
  assign state_dbg      = state;

  lsu_align u_align (
    .word       (dm_dout),
    .lane       (lane_q),
    .op         (op_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_misaligned)          state_nxt = RESP;
          else if (is_load(bus.req_op)) state_nxt = LOAD;
          else if (bus.req_op == OP_SW) state_nxt = WSETUP;
          else                         state_nxt = RMW_RD;
        end
      end
      LOAD:    state_nxt = RESP;
      RMW_RD:  state_nxt = WSETUP;
      WSETUP:  state_nxt = WSTROBE;
      WSTROBE: state_nxt = RESP;
      RESP:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= OP_LW;
      lane_q       <= 2'b00;
      wdata_q      <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      dm_addr      <= '0;
      dm_din       <= '0;
      dm_wr        <= 1'b0;
    end else begin
      // Strobe is high exactly while the FSM sits in WSTROBE, but comes
      // from a flop so DM never sees a combinational glitch.
      dm_wr <= (state_nxt == WSTROBE);
      case (state)
        IDLE: begin
          if (accept) begin
            op_q         <= bus.req_op;
            lane_q       <= bus.req_addr[1:0];
            wdata_q      <= bus.req_wdata;
            dm_addr      <= bus.req_addr[ADDR_W-1:2];
            resp_err_q   <= req_misaligned;
            resp_rdata_q <= '0;
            if (!req_misaligned && bus.req_op == OP_SW) dm_din <= bus.req_wdata;
          end
        end
        LOAD:    resp_rdata_q <= load_data;
        RMW_RD:  dm_din       <= store_word;
        default: ;
      endcase
    end
  end

endmodule
